// File: rtl/qos_stream_scheduler.sv
// Packet-level N:1 stream scheduler: highest effective QoS wins, round-robin
// among ties, grant held until the packet's last beat, aging promotes starved streams.
module qos_stream_scheduler #(
  parameter int unsigned STREAM_COUNT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned QOS_W        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [STREAM_COUNT-1:0]          s_valid,
  input  logic [STREAM_COUNT-1:0]          s_last,
  input  logic [STREAM_COUNT*DATA_W-1:0]   s_data,
  input  logic [STREAM_COUNT*QOS_W-1:0]    s_qos,
  output logic [STREAM_COUNT-1:0]          s_ready,
  output logic                             m_valid,
  output logic                             m_last,
  output logic [DATA_W-1:0]                m_data,
  output logic [$clog2(STREAM_COUNT)-1:0]  m_id,
  input  logic                             m_ready
);

  localparam int unsigned ID_W  = $clog2(STREAM_COUNT);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LVL_W = QOS_W + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                  state, state_nxt;
  logic [ID_W-1:0]         sel;
  logic [ID_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        age_cnt [STREAM_COUNT];
  logic [STREAM_COUNT-1:0] promoted;

  logic [DATA_W-1:0]       data_arr [STREAM_COUNT];
  logic [QOS_W-1:0]        qos_arr  [STREAM_COUNT];
  logic [ID_W-1:0]         win_id_c;
  logic                    arb_go_c;
  logic                    last_done_c;

  // Unpack flat per-stream buses
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      data_arr[i] = s_data[i*DATA_W +: DATA_W];
      qos_arr[i]  = s_qos[i*QOS_W +: QOS_W];
    end
  end

  // Winner: highest effective level, first hit scanning from rr_ptr+1 with wrap
  always_comb begin
    logic [ID_W:0]    idx_sum;
    logic [ID_W-1:0]  idx;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] best_lvl;
    logic             found;
    win_id_c = '0;
    best_lvl = '0;
    found    = 1'b0;
    idx_sum  = '0;
    idx      = '0;
    lvl      = '0;
    for (int k = 1; k <= STREAM_COUNT; k++) begin
      idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(STREAM_COUNT))
        idx_sum = idx_sum - (ID_W+1)'(STREAM_COUNT);
      idx = ID_W'(idx_sum);
      lvl = promoted[idx] ? {1'b1, {QOS_W{1'b0}}} : {1'b0, qos_arr[idx]};
      if (s_valid[idx] && (!found || (lvl > best_lvl))) begin
        found    = 1'b1;
        best_lvl = lvl;
        win_id_c = idx;
      end
    end
  end

  assign arb_go_c    = (state == IDLE) && (|s_valid);
  assign last_done_c = (state == XFER) && s_valid[sel] && m_ready && s_last[sel];

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go_c)    state_nxt = XFER;
      XFER:    if (last_done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: selected stream is passed straight through while granted
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    if (state == XFER) begin
      m_valid      = s_valid[sel];
      m_last       = s_last[sel];
      m_data       = data_arr[sel];
      s_ready[sel] = m_ready;
    end
  end

  // Grant, round-robin pointer and aging state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sel      <= '0;
      m_id     <= '0;
      rr_ptr   <= '0;
      promoted <= '0;
      for (int i = 0; i < STREAM_COUNT; i++) age_cnt[i] <= '0;
    end else begin
      if (arb_go_c) begin
        sel  <= win_id_c;
        m_id <= win_id_c;
        for (int i = 0; i < STREAM_COUNT; i++) begin
          if (ID_W'(i) == win_id_c) begin
            age_cnt[i]  <= '0;
            promoted[i] <= 1'b0;
          end else if (s_valid[i] && (age_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
            age_cnt[i] <= age_cnt[i] + CNT_W'(1);
            if (age_cnt[i] == CNT_W'(STARVE_LIMIT - 1)) promoted[i] <= 1'b1;
          end
        end
      end
      if (last_done_c) rr_ptr <= sel;
    end
  end

endmodule

// File: tb/tb_qos_stream_scheduler.sv
// Directed bench for qos_stream_scheduler: 4-stream instance plus a 3-stream
// instance for the non-power-of-two round-robin wrap.
module tb_qos_stream_scheduler;

  logic        clk;
  logic        nrst;
  logic [3:0]  s_valid, s_last, s_ready;
  logic [31:0] s_data;
  logic [7:0]  s_qos;
  logic        m_valid, m_last, m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_id;

  logic [2:0]  t_valid, t_last, t_ready;
  logic [23:0] t_data;
  logic [5:0]  t_qos;
  logic        t_m_valid, t_m_last, t_m_ready;
  logic [7:0]  t_m_data;
  logic [1:0]  t_m_id;

  int n_vec;
  int n_err;

  qos_stream_scheduler #(.STREAM_COUNT(4), .DATA_W(8), .QOS_W(2), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .nrst(nrst),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_qos(s_qos),
    .s_ready(s_ready),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_id(m_id),
    .m_ready(m_ready)
  );

  qos_stream_scheduler #(.STREAM_COUNT(3), .DATA_W(8), .QOS_W(2), .STARVE_LIMIT(8)) u_dut3 (
    .clk(clk), .nrst(nrst),
    .s_valid(t_valid), .s_last(t_last), .s_data(t_data), .s_qos(t_qos),
    .s_ready(t_ready),
    .m_valid(t_m_valid), .m_last(t_m_last), .m_data(t_m_data), .m_id(t_m_id),
    .m_ready(t_m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int i, input logic v, input logic l, input logic [7:0] d,
                     input logic [1:0] q);
    s_valid[i]        = v;
    s_last[i]         = l;
    s_data[i*8 +: 8]  = d;
    s_qos[i*2 +: 2]   = q;
  endtask

  task automatic clear_all();
    s_valid = '0; s_last = '0; s_data = '0; s_qos = '0;
  endtask

  initial begin
    int rr_exp [5];
    n_vec = 0;
    n_err = 0;
    nrst = 1'b0;
    m_ready = 1'b0;
    clear_all();
    t_valid = '0; t_last = '0; t_data = '0; t_qos = '0; t_m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_last",  32'(m_last),  32'h0);
    chk("rst_m_data",  32'(m_data),  32'h0);
    chk("rst_m_id",    32'(m_id),    32'h0);
    nrst = 1'b1;

    // QoS priority: stream 2 (qos 3) beats stream 0 (qos 1)
    m_ready = 1'b1;
    drv(0, 1'b1, 1'b1, 8'hA0, 2'd1);
    drv(2, 1'b1, 1'b1, 8'hC0, 2'd3);
    #1;
    chk("qos_idle_valid", 32'(m_valid), 32'h0);
    tick();
    chk("qos_id_first",    32'(m_id),    32'h2);
    chk("qos_valid_first", 32'(m_valid), 32'h1);
    chk("qos_data_first",  32'(m_data),  32'hC0);
    chk("qos_ready_first", 32'(s_ready), 32'h4);
    tick();
    drv(2, 1'b0, 1'b0, 8'h00, 2'd0);
    #1;
    chk("qos_bubble_valid", 32'(m_valid), 32'h0);
    chk("qos_bubble_id",    32'(m_id),    32'h2);
    tick();
    chk("qos_id_second",    32'(m_id),    32'h0);
    chk("qos_data_second",  32'(m_data),  32'hA0);
    chk("qos_ready_second", 32'(s_ready), 32'h1);
    tick();
    clear_all();

    // Round-robin tie: all qos 2, single-beat packets
    rr_exp[0] = 1; rr_exp[1] = 2; rr_exp[2] = 3; rr_exp[3] = 0; rr_exp[4] = 1;
    for (int i = 0; i < 4; i++) drv(i, 1'b1, 1'b1, 8'(8'h10 + i), 2'd2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_id",    32'(m_id),   32'(rr_exp[k]));
      chk("rr_data",  32'(m_data), 32'(8'h10 + rr_exp[k]));
      tick();
      if (k == 4) clear_all();
      #1;
      chk("rr_bubble", 32'(m_valid), 32'h0);
    end

    // Reset mid-packet, then first grant searches from index 1
    for (int i = 0; i < 4; i++) drv(i, 1'b1, 1'b0, 8'(8'h20 + i), 2'd0);
    tick();
    chk("mid_id_pre",    32'(m_id),    32'h2);
    chk("mid_valid_pre", 32'(m_valid), 32'h1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_s_ready", 32'(s_ready), 32'h0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_m_data",  32'(m_data),  32'h0);
    chk("mid_rst_m_id",    32'(m_id),    32'h0);
    #1;
    nrst = 1'b1;
    tick();
    chk("post_rst_id", 32'(m_id), 32'h1);
    nrst = 1'b0;
    clear_all();
    #2;
    nrst = 1'b1;

    // Grant lock with backpressure; stream 3 raises qos mid-packet
    drv(1, 1'b1, 1'b0, 8'h31, 2'd1);
    tick();
    chk("lock_id", 32'(m_id), 32'h1);
    drv(3, 1'b1, 1'b1, 8'h3F, 2'd3);
    #1;
    chk("lock_b1_data",  32'(m_data),  32'h31);
    chk("lock_b1_ready", 32'(s_ready), 32'h2);
    tick();
    drv(1, 1'b1, 1'b0, 8'h32, 2'd1);
    m_ready = 1'b0;
    #1;
    chk("lock_stall_data",  32'(m_data),  32'h32);
    chk("lock_stall_ready", 32'(s_ready), 32'h0);
    chk("lock_stall_id",    32'(m_id),    32'h1);
    tick();
    m_ready = 1'b1;
    #1;
    chk("lock_b2_data",  32'(m_data),  32'h32);
    chk("lock_b2_ready", 32'(s_ready), 32'h2);
    tick();
    drv(1, 1'b1, 1'b1, 8'h33, 2'd1);
    #1;
    chk("lock_b3_data",  32'(m_data),  32'h33);
    chk("lock_b3_last",  32'(m_last),  32'h1);
    chk("lock_b3_ready", 32'(s_ready), 32'h2);
    tick();
    drv(1, 1'b0, 1'b0, 8'h00, 2'd0);
    #1;
    chk("lock_end_valid", 32'(m_valid), 32'h0);
    tick();
    chk("lock_next_id",   32'(m_id),   32'h3);
    chk("lock_next_data", 32'(m_data), 32'h3F);
    tick();
    clear_all();

    // Starvation: stream 0 (qos 0) loses 8 times, then is promoted
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    drv(0, 1'b1, 1'b1, 8'h40, 2'd0);
    drv(1, 1'b1, 1'b1, 8'h41, 2'd3);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("starve_hi_id", 32'(m_id), 32'h1);
      tick();
      chk("starve_bubble", 32'(m_valid), 32'h0);
    end
    chk("starve_cnt_sat",  32'(u_dut.age_cnt[0]),  32'h8);
    chk("starve_promoted", 32'(u_dut.promoted[0]), 32'h1);
    tick();
    chk("starve_win_id",   32'(m_id),   32'h0);
    chk("starve_win_data", 32'(m_data), 32'h40);
    chk("starve_cnt_clr",  32'(u_dut.age_cnt[0]),  32'h0);
    chk("starve_prom_clr", 32'(u_dut.promoted[0]), 32'h0);
    tick();
    clear_all();

    // 3-stream wrap: rr_ptr=2, streams 0/1 equal qos -> stream 0
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    t_valid = 3'b100; t_last = 3'b111; t_data = 24'h525150; t_qos = 6'b010101;
    tick();
    chk("wrap_first_id", 32'(t_m_id), 32'h2);
    tick();
    t_valid = 3'b011;
    #1;
    chk("wrap_bubble", 32'(t_m_valid), 32'h0);
    tick();
    chk("wrap_id",    32'(t_m_id),    32'h0);
    chk("wrap_data",  32'(t_m_data),  32'h50);
    chk("wrap_last",  32'(t_m_last),  32'h1);
    chk("wrap_ready", 32'(t_ready),   32'h1);
    tick();
    chk("wrap_single_idle", 32'(t_m_valid), 32'h0);
    t_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qos_stream_scheduler.md
Name: qos_stream_scheduler

Overview:
- Packet-level N:1 stream scheduler placed in front of the shared output stream.
- Selects the requesting stream with the highest QoS level. Ties between equal levels are broken round-robin.
- The grant is locked to one stream until the last beat of its packet has been accepted.
- Per-stream aging counters promote starved streams so that low-QoS traffic cannot be locked out indefinitely.

Parameters:
- STREAM_COUNT, 4, number of input streams (>=2).
- DATA_W, 8, payload width per beat.
- QOS_W, 2, QoS level width; a higher value means higher priority.
- STARVE_LIMIT, 8, number of lost arbitrations before a stream is promoted (>=1).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- s_valid  in  STREAM_COUNT  per-stream beat valid.
- s_last  in  STREAM_COUNT  per-stream last beat of packet.
- s_data  in  STREAM_COUNT*DATA_W  per-stream payload; stream i occupies bits [i*DATA_W +: DATA_W].
- s_qos  in  STREAM_COUNT*QOS_W  per-stream QoS level; stream i occupies bits [i*QOS_W +: QOS_W].
- s_ready  out  STREAM_COUNT  per-stream ready.
- m_valid  out  1  output beat valid.
- m_last  out  1  output last beat.
- m_data  out  DATA_W  output payload.
- m_id  out  $clog2(STREAM_COUNT)  index of the granted stream.
- m_ready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, nrst low):
  - state=IDLE; sel=0; rr_ptr=0; all aging counters=0; promoted flags=0.
  - Outputs: s_ready=0, m_valid=0, m_last=0, m_data=0, m_id=0.
- States: IDLE, XFER.
- IDLE:
  - All s_ready=0 and m_valid=0.
  - If any s_valid is high, arbitrate and go to XFER on the next edge. This is a 1-cycle arbitration latency.
  - Otherwise stay in IDLE.
- Effective level:
  - Stream i's effective level is 2^QOS_W (above any raw level) if promoted[i]=1.
  - Otherwise it is s_qos[i].
  - Only valid streams compete.
- Winner selection:
  - Take the maximum effective level among valid streams.
  - Among the streams at that level, pick the first index at or after (rr_ptr+1) mod STREAM_COUNT, wrapping around.
- Arbitration edge:
  - sel and m_id are registered to the winner.
  - Aging counter of the winner is cleared and its promoted flag is cleared.
  - For every other stream that had s_valid=1: counter increments. When the counter reaches STARVE_LIMIT, set promoted=1 and hold the counter saturated.
  - Non-valid losers keep their counter and flag unchanged.
- XFER:
  - m_valid=s_valid[sel], m_last=s_last[sel], m_data=s_data[sel], all combinational.
  - s_ready[sel]=m_ready; all other s_ready=0.
  - A beat transfers when m_valid and m_ready are both high.
  - Transfer with m_last=1: rr_ptr<=sel and go to IDLE. This leaves one bubble cycle before the next grant.
  - A gap (s_valid[sel]=0) inside a packet keeps the grant. There is no timeout.
- Grant lock:
  - Changes to s_qos, s_valid or promoted state of other streams during XFER do not pre-empt the current packet.
  - Promotion is only evaluated in IDLE.
- Simultaneous promotion: if several streams are promoted at once, ties between them are resolved by the round-robin rule.
- Single-beat packets: s_last=1 on the first beat is legal and returns to IDLE after one transfer.
- m_id is held at its last value in IDLE.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is abandoned and the upstream is responsible for it.
- Width rules:
  - Aging counters are $clog2(STARVE_LIMIT+1) bits wide and saturate.
  - rr_ptr wraps modulo STREAM_COUNT; STREAM_COUNT need not be a power of two.

Test Plan:
- Reset: assert nrst=0 mid-XFER -> all outputs 0 immediately; first grant after release follows a search starting at index 1.
- QoS priority: streams 0 and 2 valid with qos=1 and qos=3 -> m_id=2 one cycle after valid. After stream 2's last beat, one IDLE cycle, then m_id=0.
- Round-robin tie: all 4 streams valid with qos=2, 1-beat packets, m_ready=1 -> grant order 1,2,3,0,1 with one bubble between each.
- Grant lock/backpressure: stream 1 sending a 3-beat packet; m_ready toggles 1,0,1,1; stream 3 raises qos=3 mid-packet -> all 3 beats come from m_id=1 in order; s_ready[3] stays 0 throughout; stream 3 is granted next.
- Starvation (STARVE_LIMIT=8): stream 0 qos=0 continuously valid, stream 1 qos=3 sending back-to-back packets -> stream 0 loses 8 arbitrations, then wins the 9th arbitration; its counter returns to 0 after the grant.
- Wrap and single beat: STREAM_COUNT=3, rr_ptr=2, streams 0 and 1 valid with equal qos -> stream 0 granted; a 1-beat packet with s_last=1 returns to IDLE after a single transfer.
